dht11_responder: RTL and testbench
==================================

DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock in Hz; must be an integer multiple of 1_000_000.
REQ-002 Parameter START_MIN_US, default 18000, minimum host low time, in us, accepted as a start request.
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port dht_in  input  1  sampled level of the shared single-wire bus (pulled up externally).
REQ-006 Port dht_drive_low  output  1  1 = pull the bus low; 0 = release it (open-drain enable).
REQ-007 Ports humid_int, humid_dec, temp_int, temp_dec  input  8 each  sensor payload bytes to transmit.
REQ-008 Port busy  output  1  high from start acceptance until the frame ends.
REQ-009 Port frame_done  output  1  one-cycle pulse when a full 40-bit frame plus end pulse has completed.

Function
REQ-010 dht_in shall pass through a 2-flop synchronizer; all decisions use the synchronized level.
REQ-011 A 1 us tick shall be derived from clk; all timing below is counted in whole ticks.
REQ-012 FSM states: IDLE, HOST_LOW, WAIT_REL, DELAY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-013 IDLE -> HOST_LOW on a synchronized falling edge; the low-time counter is cleared.
REQ-014 HOST_LOW: if the line rises before START_MIN_US, return to IDLE without response; at START_MIN_US go to WAIT_REL.
REQ-015 WAIT_REL: on line high, go to DELAY; snapshot the four payload bytes and checksum = (hi+hd+ti+td) mod 256; assert busy.
REQ-016 DELAY 30 us released; ACK_LOW 80 us driven low; ACK_HIGH 80 us released.
REQ-017 Each bit: BIT_LOW 50 us driven low, then BIT_HIGH released for 26 us (bit 0) or 70 us (bit 1).
REQ-018 Bit order: humid_int, humid_dec, temp_int, temp_dec, checksum; MSB first within each byte; 40 bits total.
REQ-019 After bit 39 high phase: END_LOW 50 us driven low, then release, pulse frame_done, deassert busy, go to IDLE.
REQ-020 Payload input changes after the snapshot shall not affect the frame in progress.
REQ-021 Bus activity by the host while busy shall be ignored; no restart until IDLE is reached.
REQ-022 dht_drive_low shall be registered and high only in ACK_LOW, BIT_LOW and END_LOW.
REQ-023 Phase durations shall be exact to within +0/-1 tick relative to the tick on which the state is entered.

Reset
REQ-024 On rst: state IDLE, dht_drive_low 0, busy 0, frame_done 0, counters and bit index 0, synchronizer to 1.
REQ-025 Reset asserted mid-frame shall release the bus within the same cycle the reset is asserted; no partial frame resumes.

Configuration
REQ-026 Macro DHT11_RESP_ERR_INJ_EN: when defined, adds input err_inj (1 bit); if high at snapshot, transmitted checksum is bitwise inverted.
REQ-027 Without DHT11_RESP_ERR_INJ_EN: no err_inj port; the checksum is always correct.

Structure
REQ-028 Package dht11_pkg holds the state enum and timing constants (30/80/80/50/26/70/50 us) shared with the host-side DHT11 controller.
REQ-029 Sub-module tick_gen_1us (parameter CLK_FREQ, output single-cycle tick) generates the 1 us tick.

Verification
REQ-030 Host low 18 ms then release; payload 0x37,0x00,0x19,0x05 -> 30 us, 80 low, 80 high, 40 bits decoding 0x37 00 19 05 55, frame_done pulse.
REQ-031 Host low 5 ms (START_MIN_US=18000) -> no bus drive, busy stays 0.
REQ-032 Change humid_int 0x37->0xFF during bit 3 -> frame still carries 0x37 and checksum 0x55.
REQ-033 Assert rst during BIT_LOW of bit 20 -> dht_drive_low 0 that cycle; next 18 ms start yields a complete correct frame.
REQ-034 Payload 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC (wrap); all bit-high phases measure 70 us.
REQ-035 With DHT11_RESP_ERR_INJ_EN, err_inj=1, payload 0x37,0x00,0x19,0x05 -> transmitted checksum 0xAA.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: responder FSM states, protocol phase durations in
// microseconds, and the payload checksum.
package dht11_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HOST_LOW,
        WAIT_REL,
        DELAY,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    localparam int unsigned T_DELAY_US     = 30;
    localparam int unsigned T_ACK_LOW_US   = 80;
    localparam int unsigned T_ACK_HIGH_US  = 80;
    localparam int unsigned T_BIT_LOW_US   = 50;
    localparam int unsigned T_BIT0_HIGH_US = 26;
    localparam int unsigned T_BIT1_HIGH_US = 70;
    localparam int unsigned T_END_LOW_US   = 50;

    function automatic logic [7:0] dht_checksum(input logic [7:0] hi, input logic [7:0] hd,
                                                input logic [7:0] ti, input logic [7:0] td);
        return hi + hd + ti + td;
    endfunction

endpackage

// File: rtl/tick_gen_1us.sv
// Single-cycle tick once per microsecond; CLK_FREQ must be a multiple of 1 MHz.
module tick_gen_1us #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = CLK_FREQ / 1_000_000;
    localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects the host start pulse and transmits a
// 40-bit frame. Optional DHT11_RESP_ERR_INJ_EN adds err_inj to invert the checksum.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned START_MIN_US = 18000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_drive_low,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_ERR_INJ_EN
    input  logic       err_inj,
`endif
    output logic       busy,
    output logic       frame_done
);

    state_t      state;
    logic        tick;
    logic [1:0]  sync;
    logic        line;
    logic        line_d;
    logic [15:0] cnt;
    logic [15:0] dur;
    logic [5:0]  bit_idx;
    logic [39:0] frame;
    logic [7:0]  csum;
    logic        phase_end;

    tick_gen_1us #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else     sync <= {sync[0], dht_in};
    end
    assign line = sync[1];

`ifdef DHT11_RESP_ERR_INJ_EN
    assign csum = dht_checksum(humid_int, humid_dec, temp_int, temp_dec) ^ {8{err_inj}};
`else
    assign csum = dht_checksum(humid_int, humid_dec, temp_int, temp_dec);
`endif

    always_comb begin
        dur = 16'(START_MIN_US);
        unique case (state)
            DELAY:    dur = 16'(T_DELAY_US);
            ACK_LOW:  dur = 16'(T_ACK_LOW_US);
            ACK_HIGH: dur = 16'(T_ACK_HIGH_US);
            BIT_LOW:  dur = 16'(T_BIT_LOW_US);
            BIT_HIGH: dur = frame[39] ? 16'(T_BIT1_HIGH_US) : 16'(T_BIT0_HIGH_US);
            END_LOW:  dur = 16'(T_END_LOW_US);
            default:  dur = 16'(START_MIN_US);
        endcase
    end

    // Phases close on the tick that completes their duration, so a phase entered on a tick is exact.
    assign phase_end = tick && (cnt == dur - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            line_d        <= 1'b1;
            cnt           <= '0;
            bit_idx       <= '0;
            frame         <= '0;
            dht_drive_low <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            line_d     <= line;
            frame_done <= 1'b0;
            if (tick && state != IDLE && state != WAIT_REL)
                cnt <= phase_end ? '0 : cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (line_d && !line) state <= HOST_LOW;
                end
                HOST_LOW: begin
                    if (line)           state <= IDLE;
                    else if (phase_end) state <= WAIT_REL;
                end
                WAIT_REL: begin
                    cnt <= '0;
                    if (line) begin
                        state <= DELAY;
                        frame <= {humid_int, humid_dec, temp_int, temp_dec, csum};
                        busy  <= 1'b1;
                    end
                end
                DELAY: if (phase_end) begin
                    state         <= ACK_LOW;
                    dht_drive_low <= 1'b1;
                end
                ACK_LOW: if (phase_end) begin
                    state         <= ACK_HIGH;
                    dht_drive_low <= 1'b0;
                end
                ACK_HIGH: if (phase_end) begin
                    state         <= BIT_LOW;
                    bit_idx       <= '0;
                    dht_drive_low <= 1'b1;
                end
                BIT_LOW: if (phase_end) begin
                    state         <= BIT_HIGH;
                    dht_drive_low <= 1'b0;
                end
                BIT_HIGH: if (phase_end) begin
                    frame         <= frame << 1;
                    dht_drive_low <= 1'b1;
                    if (bit_idx == 6'd39) begin
                        state <= END_LOW;
                    end else begin
                        state   <= BIT_LOW;
                        bit_idx <= bit_idx + 6'd1;
                    end
                end
                END_LOW: if (phase_end) begin
                    state         <= IDLE;
                    dht_drive_low <= 1'b0;
                    busy          <= 1'b0;
                    frame_done    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder at a 2 MHz clock (1 us = 2 cycles) with a
// 100 us start threshold; the host is modelled as an open-drain pull-down.
module tb_dht11_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic       dht_in;
    logic       dht_drive_low;
    logic [7:0] humid_int = 8'h37;
    logic [7:0] humid_dec = 8'h00;
    logic [7:0] temp_int  = 8'h19;
    logic [7:0] temp_dec  = 8'h05;
    logic       busy;
    logic       frame_done;
`ifdef DHT11_RESP_ERR_INJ_EN
    logic       err_inj = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    assign dht_in = host_low ? 1'b0 : ~dht_drive_low;

    always #5 clk = ~clk;

    dht11_responder #(
        .CLK_FREQ     (2_000_000),
        .START_MIN_US (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dht_in        (dht_in),
        .dht_drive_low (dht_drive_low),
        .humid_int     (humid_int),
        .humid_dec     (humid_dec),
        .temp_int      (temp_int),
        .temp_dec      (temp_dec),
`ifdef DHT11_RESP_ERR_INJ_EN
        .err_inj       (err_inj),
`endif
        .busy          (busy),
        .frame_done    (frame_done)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts negedges while dht_drive_low holds lvl; returns at the first negedge it differs.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (dht_drive_low === lvl && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic host_start(input int low_cycles);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_cycles) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [39:0] exp,
                             input int change_bit, input int rst_bit);
        int n, lo, hi, bad_lo, bad_hi;
        logic [39:0] got;
        bit aborted;
        bad_lo = 0; bad_hi = 0; got = '0; aborted = 1'b0;
        host_start(250);
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy"}, 40'(busy), 40'd1);
        measure(1'b0, n);
        check({tag, "_delay"}, 40'(n == 59 || n == 60), 40'd1);
        measure(1'b1, n);
        check({tag, "_ack_low"}, 40'(n), 40'd160);
        measure(1'b0, n);
        check({tag, "_ack_high"}, 40'(n), 40'd160);
        for (int i = 0; i < 40; i++) begin
            if (i == change_bit) humid_int = 8'hFF;
            if (i == rst_bit) begin
                check({tag, "_in_bit_low"}, 40'(dht_drive_low), 40'd1);
                rst = 1'b1;
                #1;
                check({tag, "_rst_release"}, 40'(dht_drive_low), 40'd0);
                check({tag, "_rst_busy"}, 40'(busy), 40'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            measure(1'b1, lo);
            measure(1'b0, hi);
            if (lo >= 1000 || hi >= 1000) begin
                check({tag, "_phase_bound"}, 40'(lo < 1000 && hi < 1000), 40'd1);
                aborted = 1'b1;
                break;
            end
            if (lo != 100) bad_lo++;
            if (!(hi == 52 || hi == 140)) bad_hi++;
            got = {got[38:0], hi > 100};
        end
        if (!aborted) begin
            check({tag, "_bit_low_len"}, 40'(bad_lo), 40'd0);
            check({tag, "_bit_high_len"}, 40'(bad_hi), 40'd0);
            check({tag, "_frame"}, got, exp);
            measure(1'b1, n);
            check({tag, "_end_low"}, 40'(n), 40'd100);
            check({tag, "_done_pulse"}, 40'(frame_done), 40'd1);
            check({tag, "_busy_end"}, 40'(busy), 40'd0);
            @(negedge clk);
            check({tag, "_done_1cyc"}, 40'(frame_done), 40'd0);
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n_drive, n_busy;
        repeat (3) @(negedge clk);
        check("rst_drive", 40'(dht_drive_low), 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_done", 40'(frame_done), 40'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        run_frame("basic", 40'h37_00_19_05_55, -1, -1);

        host_start(120);
        n_drive = 0; n_busy = 0;
        repeat (400) begin
            @(negedge clk);
            if (dht_drive_low) n_drive++;
            if (busy) n_busy++;
        end
        check("short_drive", 40'(n_drive), 40'd0);
        check("short_busy", 40'(n_busy), 40'd0);

        run_frame("snapshot", 40'h37_00_19_05_55, 3, -1);
        humid_int = 8'h37;

        run_frame("midrst", 40'h37_00_19_05_55, -1, 20);
        run_frame("after_rst", 40'h37_00_19_05_55, -1, -1);

        humid_int = 8'hFF; humid_dec = 8'hFF; temp_int = 8'hFF; temp_dec = 8'hFF;
        run_frame("wrap", 40'hFF_FF_FF_FF_FC, -1, -1);

`ifdef DHT11_RESP_ERR_INJ_EN
        humid_int = 8'h37; humid_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
        err_inj = 1'b1;
        run_frame("err_inj", 40'h37_00_19_05_AA, -1, -1);
        err_inj = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
